// File: rtl/song_pkg.sv
// Shared types and helpers for the multi-song limit table and playback sequencer.
package song_pkg;

    // Widest note-memory address the table entry can hold.
    localparam int SONG_ADDR_W_MAX = 16;

    // Sequencer states.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } seq_state_e;

    // One table entry; the limit is kept zero-extended to the widest address.
    typedef struct packed {
        logic                       valid;
        logic [SONG_ADDR_W_MAX-1:0] limit;
    } song_entry_t;

    // Width of a song-slot index; always at least one bit.
    function automatic int song_w_f(input int num_songs);
        return (num_songs > 2) ? $clog2(num_songs) : 1;
    endfunction

    // Entry value after a record strobe: last-written, or running maximum.
    function automatic song_entry_t entry_record_f(
        input song_entry_t                cur,
        input logic [SONG_ADDR_W_MAX-1:0] addr,
        input logic                       track_max
    );
        song_entry_t nxt;
        nxt.valid = 1'b1;
        if (!track_max || !cur.valid || (addr > cur.limit)) begin
            nxt.limit = addr;
        end else begin
            nxt.limit = cur.limit;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/song_play_seq.sv
// Playback sequencer: snapshots a song's limit at start and walks the read
// address from 0 up to that limit, once or looping.
module song_play_seq
    import song_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              play_start,
    input  logic              play_song_valid,
    input  logic [ADDR_W-1:0] play_song_limit,
    input  logic              play_loop,
    input  logic              play_stop,
    input  logic              note_tick,
    output logic [ADDR_W-1:0] play_addr,
    output logic              play_active,
    output logic              play_done
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] snap_q, snap_d;
    logic              loop_q, loop_d;
    logic              done_q, done_d;
    logic              at_end_s;

    assign at_end_s = (addr_q == snap_q);

    // State, snapshot, address and done-pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            snap_q  <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            snap_q  <= snap_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    // Next-state: stop beats start, start beats tick; invalid start lands in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!play_stop && play_start && play_song_valid) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (play_stop) begin
                    state_d = S_IDLE;
                end else if (play_start) begin
                    state_d = play_song_valid ? S_PLAY : S_IDLE;
                end else if (note_tick && at_end_s && !loop_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: snapshot on accepted start, advance/wrap on tick, raise done at the end.
    always_comb begin
        addr_d = addr_q;
        snap_d = snap_q;
        loop_d = loop_q;
        done_d = 1'b0;
        if (play_stop) begin
            done_d = 1'b0;
        end else if (play_start) begin
            if (play_song_valid) begin
                addr_d = '0;
                snap_d = play_song_limit;
                loop_d = play_loop;
            end else begin
                done_d = 1'b1;
            end
        end else if ((state_q == S_PLAY) && note_tick) begin
            if (addr_q < snap_q) begin
                addr_d = addr_q + ADDR_W'(1'b1);
            end else if (loop_q) begin
                addr_d = '0;
            end else begin
                done_d = 1'b1;
            end
        end else begin
            done_d = 1'b0;
        end
    end

    assign play_addr   = addr_q;
    assign play_active = (state_q == S_PLAY);
    assign play_done   = done_q;

endmodule

// File: rtl/song_limit_table.sv
// Per-song end-address table with clear/record priority, a registered read
// port, and the playback sequencer that walks a selected song.
module song_limit_table
    import song_pkg::*;
#(
    parameter  int NUM_SONGS = 4,
    parameter  int ADDR_W    = 6,
    parameter  int TRACK_MAX = 0,
    localparam int SONG_W    = song_w_f(NUM_SONGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rec_cs,
    input  logic [SONG_W-1:0] rec_song,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic              clean_limite,
    input  logic [SONG_W-1:0] clean_song,
    input  logic              play_start,
    input  logic [SONG_W-1:0] play_song,
    input  logic              play_loop,
    input  logic              play_stop,
    input  logic              note_tick,
    output logic [ADDR_W-1:0] play_addr,
    output logic              play_active,
    output logic              play_done,
    input  logic [SONG_W-1:0] rd_song,
    output logic [ADDR_W-1:0] rd_limit,
    output logic              rd_valid
);

    song_entry_t       entries_q [NUM_SONGS];
    song_entry_t       entries_d [NUM_SONGS];
    song_entry_t       play_ent_s;
    song_entry_t       rd_ent_s;
    logic [ADDR_W-1:0] rd_limit_q, rd_limit_d;
    logic              rd_valid_q, rd_valid_d;

    // Table update: a clear of a slot overrides a same-cycle record of that slot.
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < NUM_SONGS; i++) begin
            if (clean_limite && (clean_song == SONG_W'(i))) begin
                entries_d[i] = '0;
            end else if (rec_cs && (rec_song == SONG_W'(i))) begin
                entries_d[i] = entry_record_f(entries_q[i], SONG_ADDR_W_MAX'(rec_addr),
                                              (TRACK_MAX != 0));
            end else begin
                entries_d[i] = entries_q[i];
            end
        end
    end

    // Read muxes from the current table, so a start sees the pre-write value.
    always_comb begin
        play_ent_s = '0;
        rd_ent_s   = '0;
        for (int i = 0; i < NUM_SONGS; i++) begin
            play_ent_s = (play_song == SONG_W'(i)) ? entries_q[i] : play_ent_s;
            rd_ent_s   = (rd_song == SONG_W'(i))   ? entries_q[i] : rd_ent_s;
        end
        rd_limit_d = rd_ent_s.limit[ADDR_W-1:0];
        rd_valid_d = rd_ent_s.valid;
    end

    // Table storage and registered read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            entries_q  <= '{default: '0};
            rd_limit_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            rd_limit_q <= rd_limit_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_limit = rd_limit_q;
    assign rd_valid = rd_valid_q;

    song_play_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clock           (clock),
        .reset           (reset),
        .play_start      (play_start),
        .play_song_valid (play_ent_s.valid),
        .play_song_limit (play_ent_s.limit[ADDR_W-1:0]),
        .play_loop       (play_loop),
        .play_stop       (play_stop),
        .note_tick       (note_tick),
        .play_addr       (play_addr),
        .play_active     (play_active),
        .play_done       (play_done)
    );

endmodule

// File: tb/tb_song_limit_table.sv
// Bench for song_limit_table: two instances (last-written and max-tracking)
// share stimulus; vector table plus hand sequences, expectations via a queue.
module tb_song_limit_table;

    localparam int AW = 6;
    localparam int SW = 2;

    logic          clock = 1'b0;
    logic          reset, rec_cs, clean_limite, play_start, play_loop, play_stop, note_tick;
    logic [SW-1:0] rec_song, clean_song, play_song, rd_song;
    logic [AW-1:0] rec_addr;
    logic [AW-1:0] play_addr0, play_addr1, rd_limit0, rd_limit1;
    logic          play_active0, play_active1, play_done0, play_done1, rd_valid0, rd_valid1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          rc;
        logic [SW-1:0] rs;
        logic [AW-1:0] ra;
        logic          cl;
        logic [SW-1:0] cs;
        logic          st;
        logic [SW-1:0] ps;
        logic          lp;
        logic          sp;
        logic          tk;
        logic [AW-1:0] ea;
        logic          eac;
        logic          ed;
    } vec_t;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic          act;
        logic          done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 clock = ~clock;

    song_limit_table #(.NUM_SONGS(4), .ADDR_W(AW), .TRACK_MAX(0)) dut0 (
        .clock(clock), .reset(reset), .rec_cs(rec_cs), .rec_song(rec_song), .rec_addr(rec_addr),
        .clean_limite(clean_limite), .clean_song(clean_song), .play_start(play_start),
        .play_song(play_song), .play_loop(play_loop), .play_stop(play_stop), .note_tick(note_tick),
        .play_addr(play_addr0), .play_active(play_active0), .play_done(play_done0),
        .rd_song(rd_song), .rd_limit(rd_limit0), .rd_valid(rd_valid0)
    );

    song_limit_table #(.NUM_SONGS(4), .ADDR_W(AW), .TRACK_MAX(1)) dut1 (
        .clock(clock), .reset(reset), .rec_cs(rec_cs), .rec_song(rec_song), .rec_addr(rec_addr),
        .clean_limite(clean_limite), .clean_song(clean_song), .play_start(play_start),
        .play_song(play_song), .play_loop(play_loop), .play_stop(play_stop), .note_tick(note_tick),
        .play_addr(play_addr1), .play_active(play_active1), .play_done(play_done1),
        .rd_song(rd_song), .rd_limit(rd_limit1), .rd_valid(rd_valid1)
    );

    function automatic vec_t mkv(int rc, int rs, int ra, int cl, int cs, int st, int ps,
                                 int lp, int sp, int tk, int ea, int eac, int ed);
        vec_t v;
        v.rc = 1'(rc);  v.rs = SW'(rs); v.ra = AW'(ra); v.cl = 1'(cl); v.cs = SW'(cs);
        v.st = 1'(st);  v.ps = SW'(ps); v.lp = 1'(lp);  v.sp = 1'(sp); v.tk = 1'(tk);
        v.ea = AW'(ea); v.eac = 1'(eac); v.ed = 1'(ed);
        return v;
    endfunction

    function automatic vec_t vt(int ea, int eac, int ed);
        return mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ea, eac, ed);
    endfunction

    function automatic vec_t vs(int song, int lp, int ea, int eac, int ed);
        return mkv(0, 0, 0, 0, 0, 1, song, lp, 0, 0, ea, eac, ed);
    endfunction

    function automatic vec_t vn(int ea, int eac, int ed);
        return mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eac, ed);
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rec_cs = 1'b0; rec_song = '0; rec_addr = '0; clean_limite = 1'b0; clean_song = '0;
        play_start = 1'b0; play_song = '0; play_loop = 1'b0; play_stop = 1'b0; note_tick = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        exp_t e;
        rec_cs = v.rc; rec_song = v.rs; rec_addr = v.ra; clean_limite = v.cl; clean_song = v.cs;
        play_start = v.st; play_song = v.ps; play_loop = v.lp; play_stop = v.sp; note_tick = v.tk;
        sb_q.push_back('{idx: idx, addr: v.ea, act: v.eac, done: v.ed});
        cycle();
        idle_inputs();
        e = sb_q.pop_front();
        chk($sformatf("vec%0d play_addr", e.idx), int'(play_addr0), int'(e.addr));
        chk($sformatf("vec%0d play_active", e.idx), int'(play_active0), int'(e.act));
        chk($sformatf("vec%0d play_done", e.idx), int'(play_done0), int'(e.done));
    endtask

    task automatic rec(input int song, input int addr, input int cl, input int cs);
        rec_cs = 1'b1; rec_song = SW'(song); rec_addr = AW'(addr);
        clean_limite = 1'(cl); clean_song = SW'(cs);
        cycle();
        idle_inputs();
    endtask

    task automatic check_rd(input string tag, input int song,
                            input int l0, input int v0, input int l1, input int v1);
        rd_song = SW'(song);
        cycle();
        chk($sformatf("%s last rd_limit s%0d", tag, song), int'(rd_limit0), l0);
        chk($sformatf("%s last rd_valid s%0d", tag, song), int'(rd_valid0), v0);
        chk($sformatf("%s max rd_limit s%0d", tag, song), int'(rd_limit1), l1);
        chk($sformatf("%s max rd_valid s%0d", tag, song), int'(rd_valid1), v1);
    endtask

    initial begin
        idle_inputs();
        rd_song = '0;
        reset   = 1'b1;
        repeat (2) cycle();

        // Reset values.
        chk("reset play_addr", int'(play_addr0), 0);
        chk("reset play_active", int'(play_active0), 0);
        chk("reset play_done", int'(play_done0), 0);
        chk("reset rd_limit", int'(rd_limit0), 0);
        chk("reset rd_valid", int'(rd_valid0), 0);
        reset = 1'b0;
        cycle();

        // Last-written vs max: song 1 written 0..9 then 4.
        for (int a = 0; a < 10; a++) rec(1, a, 0, 0);
        rec(1, 4, 0, 0);
        check_rd("rec", 1, 4, 1, 9, 1);
        for (int s = 0; s < 4; s++) begin
            if (s != 1) check_rd("untouched", s, 0, 0, 0, 0);
        end

        // Two-cycle visibility on the read port, for record and for clear.
        rd_song = 2'd3;
        rec(3, 5, 0, 0);
        chk("lat rec +1 rd_valid", int'(rd_valid0), 0);
        cycle();
        chk("lat rec +2 rd_limit", int'(rd_limit0), 5);
        chk("lat rec +2 rd_valid", int'(rd_valid0), 1);
        clean_limite = 1'b1; clean_song = 2'd3;
        cycle();
        idle_inputs();
        chk("lat clr +1 rd_valid", int'(rd_valid0), 1);
        cycle();
        chk("lat clr +2 rd_valid", int'(rd_valid0), 0);
        chk("lat clr +2 rd_limit", int'(rd_limit0), 0);

        // Max mode on song 2, then clear and record on the same slot together.
        rec(2, 7, 0, 0); rec(2, 3, 0, 0); rec(2, 12, 0, 0); rec(2, 5, 0, 0);
        check_rd("max", 2, 5, 1, 12, 1);
        rec(2, 20, 1, 2);
        check_rd("clr+rec same", 2, 0, 0, 0, 0);
        rec(2, 8, 1, 3);
        check_rd("clr+rec diff", 2, 8, 1, 8, 1);
        check_rd("clr+rec diff", 3, 0, 0, 0, 0);

        // Playback vectors on the last-written instance: s1=4, s2=8, s0/s3 invalid.
        vecs.push_back(vt(0, 0, 0));                          // tick in IDLE ignored
        vecs.push_back(vs(1, 0, 0, 1, 0));
        for (int a = 1; a <= 4; a++) vecs.push_back(vt(a, 1, 0));
        vecs.push_back(vt(4, 0, 1));                          // end of run
        vecs.push_back(vn(4, 0, 0));
        vecs.push_back(vt(4, 0, 0));
        vecs.push_back(vs(1, 1, 0, 1, 0));                    // loop run
        for (int a = 1; a <= 4; a++) vecs.push_back(vt(a, 1, 0));
        vecs.push_back(vt(0, 1, 0));
        vecs.push_back(vt(1, 1, 0));
        vecs.push_back(vt(2, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0)); // stop + tick
        vecs.push_back(vn(2, 0, 0));
        vecs.push_back(vs(3, 0, 2, 0, 1));                    // invalid start
        vecs.push_back(vn(2, 0, 0));
        vecs.push_back(mkv(1, 1, 9, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0)); // start + re-record
        for (int a = 1; a <= 4; a++) vecs.push_back(vt(a, 1, 0));
        vecs.push_back(vt(4, 0, 1));                          // snapshot held at 4
        vecs.push_back(vs(2, 0, 0, 1, 0));
        vecs.push_back(vt(1, 1, 0));
        vecs.push_back(vs(0, 0, 1, 0, 1));                    // restart on invalid song
        vecs.push_back(vs(1, 1, 0, 1, 0));
        vecs.push_back(vt(1, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 2, 0, 1, 1, 1, 0, 0)); // stop beats start
        vecs.push_back(vs(2, 0, 0, 1, 0));
        vecs.push_back(vt(1, 1, 0));
        vecs.push_back(vs(1, 0, 0, 1, 0));                    // restart on valid song
        vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0)); // clear playing song
        vecs.push_back(vn(1, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)); // stop
        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
        check_rd("after play", 1, 0, 0, 0, 0);

        // Full-range limit 63 on song 0.
        rec(0, 63, 0, 0);
        apply_vec(vs(0, 0, 0, 1, 0), 100);
        for (int a = 1; a <= 63; a++) apply_vec(vt(a, 1, 0), 100 + a);
        apply_vec(vt(63, 0, 1), 164);
        apply_vec(vn(63, 0, 0), 165);

        // Reset during playback at address 2, with start and tick also asserted.
        apply_vec(vs(0, 1, 0, 1, 0), 200);
        apply_vec(vt(1, 1, 0), 201);
        apply_vec(vt(2, 1, 0), 202);
        reset = 1'b1; play_start = 1'b1; play_song = 2'd0; note_tick = 1'b1; rd_song = 2'd0;
        cycle();
        idle_inputs();
        chk("midreset play_addr", int'(play_addr0), 0);
        chk("midreset play_active", int'(play_active0), 0);
        chk("midreset play_done", int'(play_done0), 0);
        chk("midreset rd_limit", int'(rd_limit0), 0);
        chk("midreset rd_valid", int'(rd_valid0), 0);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) check_rd("post reset", s, 0, 0, 0, 0);
        apply_vec(vs(0, 0, 0, 0, 1), 210);                    // song 0 now invalid

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/song_limit_table.md
# song_limit_table

Per-song end-address table plus playback address sequencer for the multi-song recorder. During recording, it captures the end address of each of `NUM_SONGS` songs. During playback, it walks a selected song from address 0 to its stored limit, once or looping, and drives the note-memory read address. It sits between the record controller (write strobes) and the note memories (read address), and replaces the single-song limit register.

## Interface
Parameters:
- `NUM_SONGS`, 4: number of independent song slots, ≥2.
- `ADDR_W`, 6: note-memory address width.
- `TRACK_MAX`, 0: 0 = limit is the last address written; 1 = limit is the highest address written since the last clear.

Ports:
- `clock` in 1: single clock, all logic posedge.
- `reset` in 1: synchronous, active-high; clears the whole table and the sequencer.
- `rec_cs` in 1: record strobe; the note at `rec_addr` was written for `rec_song`.
- `rec_song` in SONG_W: song slot being recorded (SONG_W = clog2(NUM_SONGS)).
- `rec_addr` in ADDR_W: address just written.
- `clean_limite` in 1: clear the limit and valid bit of `clean_song`.
- `clean_song` in SONG_W: slot to clear.
- `play_start` in 1: request playback of `play_song`.
- `play_song` in SONG_W: slot to play.
- `play_loop` in 1: sampled at start; 1 = wrap to 0 after the limit.
- `play_stop` in 1: abort playback.
- `note_tick` in 1: advance one note.
- `play_addr` out ADDR_W: current read address.
- `play_active` out 1: sequencer in PLAY.
- `play_done` out 1: one-cycle pulse when a non-loop playback finishes or a start is rejected.
- `rd_song` in SONG_W: table read select.
- `rd_limit` out ADDR_W: registered limit of `rd_song`.
- `rd_valid` out 1: registered valid bit of `rd_song`.

## Operation
- **Table:** `NUM_SONGS` entries of {valid, limit[ADDR_W]}.
- **Record write:** `rec_cs` with `TRACK_MAX`=0 sets limit ← `rec_addr`. With `TRACK_MAX`=1, limit ← `rec_addr` if the entry is invalid or `rec_addr` > limit. Either way, valid ← 1.
- **Clear:** `clean_limite` sets limit ← 0 and valid ← 0 for `clean_song`.
- **Clear vs. write, same slot, same cycle:** clean wins. Different slots: both take effect.
- **Sequencer states:** IDLE, PLAY.
- **IDLE + `play_start`, selected song valid:** snapshot limit and `play_loop`, set `play_addr` ← 0, go to PLAY.
- **IDLE + `play_start`, selected song invalid:** stay in IDLE; pulse `play_done` on the next cycle.
- **PLAY + `note_tick`:**
  - If `play_addr` < snapshot, increment.
  - If `play_addr` == snapshot and loop is set, `play_addr` ← 0.
  - If `play_addr` == snapshot and loop is clear, go to IDLE and pulse `play_done`; `play_addr` holds its last value.
- **PLAY + `play_start`:** restart on the newly selected song, with the same validity rules as from IDLE.
- **`play_stop`:** return to IDLE; no `play_done` pulse. Stop takes priority over start and over tick in the same cycle.
- **Writes during playback:** record or clean of the song being played do not affect the running snapshot.
- **Arithmetic:** address compare is unsigned. The increment never exceeds the snapshot, so no ADDR_W overflow is possible. A limit of 2^ADDR_W−1 is legal.

## Timing
- **Reset values:** all limits 0, all valid 0, state IDLE, `play_addr` 0, `play_active` 0, `play_done` 0, `rd_limit` 0, `rd_valid` 0.
- **Reset priority:** reset mid-playback takes effect at the next edge and overrides all other inputs.
- **Table update latency:** 1 cycle. Entry is updated at the edge sampling `rec_cs`/`clean_limite`. `rd_limit`/`rd_valid` reflect it one further cycle later (2 cycles total).
- **Start latency:** `play_active` rises and `play_addr`=0 at the edge after `play_start`.
- **Tick response:** each `note_tick` moves `play_addr` at the next edge. Ticks in IDLE are ignored.
- **Done pulse:** `play_done` is high for exactly one cycle, coincident with `play_active` falling.
- **Start and write, same cycle:** `play_start` sees the table value before the same-cycle write.

## Structure
- **Package `song_pkg`:** `SONG_W` derivation function, sequencer state enum (`S_IDLE`, `S_PLAY`), table entry struct {valid, limit}.
- **Sub-module `song_play_seq`:** sequencer FSM, snapshot registers and address counter.
- **Top level:** the table, update/clear priority logic, and read port.

## Test plan
- **Last-written mode:** `TRACK_MAX`=0, record song 1 at addresses 0..9 then 4 → `rd_limit`=4, `rd_valid`=1; other songs remain 0/0.
- **Max mode:** `TRACK_MAX`=1, record song 2 at 7, 3, 12, 5 → limit 12. Then `clean_limite` and `rec_cs` on song 2 in the same cycle → limit 0, valid 0.
- **Single playback:** song 1 limit 4, start without loop, 5 ticks → `play_addr` 0,1,2,3,4. The 5th tick pulses `play_done` once and drops `play_active`.
- **Loop mode:** same song with `play_loop`=1, 7 ticks → sequence 0..4,0,1,2; no `play_done`. Then `play_stop` asserted with `note_tick` → IDLE, `play_addr` unchanged, no pulse.
- **Invalid song and snapshot:** start on an invalid song → stays IDLE, `play_done` one cycle later. Re-recording song 1 to limit 9 during playback → the run still ends at 4.
- **Mid-playback reset:** `reset` at `play_addr`=2 → next cycle all outputs at reset values and all entries invalid.
